// File: rtl/sr_bank_pkg.sv
// Shared types and the per-channel next-state rule for the SR register bank.
package sr_bank_pkg;

    typedef enum logic [1:0] {
        SR_SET_DOM = 2'd0,
        SR_RST_DOM = 2'd1,
        SR_HOLD    = 2'd2,
        SR_TOGGLE  = 2'd3
    } sr_mode_e;

    // Next state of one SR channel; the mode only matters when s and r are both high.
    function automatic logic sr_next(
        input sr_mode_e mode,
        input logic     s,
        input logic     r,
        input logic     q
    );
        logic n;
        n = q;
        case ({s, r})
            2'b00: n = q;
            2'b01: n = 1'b0;
            2'b10: n = 1'b1;
            2'b11: begin
                case (mode)
                    SR_SET_DOM: n = 1'b1;
                    SR_RST_DOM: n = 1'b0;
                    SR_HOLD:    n = q;
                    SR_TOGGLE:  n = ~q;
                    default:    n = q;
                endcase
            end
            default: n = q;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR storage channel with registered edge pulses and a sticky conflict flag.
// Latency: q, rise and fall update one edge after s/r are sampled.
// Backpressure: none; en gates sampling, clr overrides everything.
module sr_cell
    import sr_bank_pkg::*;
#(
    parameter sr_mode_e MODE      = SR_RST_DOM,
    parameter logic     RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic s,
    input  logic r,
    output logic q,
    output logic rise,
    output logic fall,
    output logic conflict,
    output logic conflict_evt
);

    logic q_next;

    always_comb begin
        q_next = q;
        if (clr) begin
            q_next = RESET_BIT;
        end else if (en) begin
            q_next = sr_next(MODE, s, r, q);
        end
    end

    // A conflict sampled in a clear cycle is discarded.
    assign conflict_evt = en & s & r & ~clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= RESET_BIT;
            rise     <= 1'b0;
            fall     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            q        <= q_next;
            rise     <= q_next & ~q;
            fall     <= ~q_next & q;
            conflict <= clr ? 1'b0 : (conflict | conflict_evt);
        end
    end

endmodule

// File: rtl/sr_reg_bank.sv
// Bank of WIDTH SR channels with shared enable/clear and a saturating conflict-cycle counter.
// Latency: all outputs registered, one edge after s/r are sampled.
// Backpressure: none; en gates sampling, clr overrides everything.
module sr_reg_bank
    import sr_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter sr_mode_e         MODE      = SR_RST_DOM,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] conflict_evt;
    logic             any_conflict;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .MODE      (MODE),
            .RESET_BIT (RESET_VAL[i])
        ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .en           (en),
            .clr          (clr),
            .s            (s[i]),
            .r            (r[i]),
            .q            (q[i]),
            .rise         (q_rise[i]),
            .fall         (q_fall[i]),
            .conflict     (conflict[i]),
            .conflict_evt (conflict_evt[i])
        );
    end

    // Counts cycles with at least one conflicting channel, not the number of channels.
    assign any_conflict = |conflict_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (clr) begin
            conflict_cnt <= '0;
        end else if (any_conflict && (conflict_cnt != CNT_MAX)) begin
            conflict_cnt <= conflict_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_sr_reg_bank.sv
// Scoreboard bench: four builds (one per mode) plus a RESET_VAL=A5/CNT_W=4 build share one stimulus stream.
module tb_sr_reg_bank;
    import sr_bank_pkg::*;

    localparam int NDUT = 5;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] conf;
        logic [7:0] cnt;
    } exp_t;
    typedef exp_t [NDUT-1:0] exp_set_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] s   = 8'h00;
    logic [7:0] r   = 8'h00;

    logic [7:0] q_o    [NDUT];
    logic [7:0] rise_o [NDUT];
    logic [7:0] fall_o [NDUT];
    logic [7:0] conf_o [NDUT];
    logic [7:0] cnt_o  [NDUT];
    logic [3:0] cnt4;

    int total = 0;
    int bad   = 0;
    exp_set_t sb_q[$];

    // Reference model state, one entry per build
    logic [7:0] m_q    [NDUT];
    logic [7:0] m_rise [NDUT];
    logic [7:0] m_fall [NDUT];
    logic [7:0] m_conf [NDUT];
    int         m_cnt  [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        logic [7:0] cnt8;
        sr_reg_bank #(
            .WIDTH     (8),
            .MODE      (sr_mode_e'(g)),
            .RESET_VAL (8'h00),
            .CNT_W     (8)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .en           (en),
            .clr          (clr),
            .s            (s),
            .r            (r),
            .q            (q_o[g]),
            .q_rise       (rise_o[g]),
            .q_fall       (fall_o[g]),
            .conflict     (conf_o[g]),
            .conflict_cnt (cnt8)
        );
        assign cnt_o[g] = cnt8;
    end

    sr_reg_bank #(
        .WIDTH     (8),
        .MODE      (SR_RST_DOM),
        .RESET_VAL (8'hA5),
        .CNT_W     (4)
    ) u_dut_a5 (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clr          (clr),
        .s            (s),
        .r            (r),
        .q            (q_o[4]),
        .q_rise       (rise_o[4]),
        .q_fall       (fall_o[4]),
        .conflict     (conf_o[4]),
        .conflict_cnt (cnt4)
    );
    assign cnt_o[4] = {4'h0, cnt4};

    function automatic logic [7:0] rv_of(int d);
        return (d == 4) ? 8'hA5 : 8'h00;
    endfunction

    function automatic int max_of(int d);
        return (d == 4) ? 15 : 255;
    endfunction

    // What an S=R=1 channel resolves to, as a whole-vector value for build d
    function automatic logic [7:0] resolve(int d, logic [7:0] cur);
        case (d)
            0: return 8'hFF;
            2: return cur;
            3: return ~cur;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step(input logic rv, input logic ev, input logic cv,
                              input logic [7:0] sv, input logic [7:0] rvv);
        logic [7:0] nq;
        logic [7:0] both;
        for (int d = 0; d < NDUT; d++) begin
            if (rv) begin
                m_q[d] = rv_of(d); m_rise[d] = 0; m_fall[d] = 0; m_conf[d] = 0; m_cnt[d] = 0;
            end else if (cv) begin
                nq = rv_of(d);
                m_rise[d] = nq & ~m_q[d];
                m_fall[d] = ~nq & m_q[d];
                m_q[d] = nq; m_conf[d] = 0; m_cnt[d] = 0;
            end else if (ev) begin
                both = sv & rvv;
                nq = (m_q[d] & ~(sv | rvv)) | (sv & ~rvv) | (both & resolve(d, m_q[d]));
                m_rise[d] = nq & ~m_q[d];
                m_fall[d] = ~nq & m_q[d];
                m_q[d] = nq;
                m_conf[d] = m_conf[d] | both;
                if (both != 0 && m_cnt[d] < max_of(d)) m_cnt[d] = m_cnt[d] + 1;
            end else begin
                m_rise[d] = 0; m_fall[d] = 0;
            end
        end
    endtask

    // Drive one cycle of stimulus on the falling edge and queue what the DUTs must show next
    task automatic step(input logic rv, input logic ev, input logic cv,
                        input logic [7:0] sv, input logic [7:0] rvv);
        exp_set_t e;
        @(negedge clk);
        en = ev; clr = cv; s = sv; r = rvv;
        rst = rv;
        model_step(rv, ev, cv, sv, rvv);
        for (int d = 0; d < NDUT; d++) begin
            e[d].q = m_q[d]; e[d].rise = m_rise[d]; e[d].fall = m_fall[d];
            e[d].conf = m_conf[d]; e[d].cnt = 8'(m_cnt[d]);
        end
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input int d, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%h exp=%h t=%0t", name, d, got, exp, $time);
        end
    endtask

    // Monitor: wakes on every clock edge and on reset assertion (to see async reset before any edge)
    initial begin
        exp_set_t e;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int d = 0; d < NDUT; d++) begin
                    chk("q",            d, q_o[d],    e[d].q);
                    chk("q_rise",       d, rise_o[d], e[d].rise);
                    chk("q_fall",       d, fall_o[d], e[d].fall);
                    chk("conflict",     d, conf_o[d], e[d].conf);
                    chk("conflict_cnt", d, cnt_o[d],  e[d].cnt);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            m_q[d] = rv_of(d); m_rise[d] = 0; m_fall[d] = 0; m_conf[d] = 0; m_cnt[d] = 0;
        end
        step(1, 0, 0, 8'h00, 8'h00);
        step(1, 0, 0, 8'h00, 8'h00);
        // basic set then reset
        step(0, 1, 0, 8'h0F, 8'h00);
        step(0, 1, 0, 8'h00, 8'h00);
        step(0, 1, 0, 8'h00, 8'h03);
        // mode sweep from q=0F, toggle build sees two conflict cycles
        step(0, 1, 0, 8'h0F, 8'hF0);
        step(0, 1, 0, 8'hFF, 8'hFF);
        step(0, 1, 0, 8'hFF, 8'hFF);
        step(0, 1, 0, 8'h00, 8'h00);
        // enable gating
        step(0, 0, 0, 8'hFF, 8'h01);
        step(0, 0, 0, 8'hFF, 8'h01);
        // clear priority from q=3C with one sticky conflict
        step(0, 0, 1, 8'h00, 8'h00);
        step(0, 1, 0, 8'h3C, 8'hC3);
        step(0, 1, 0, 8'h01, 8'h01);
        step(0, 1, 0, 8'h3C, 8'hC2);
        step(0, 1, 1, 8'hFF, 8'hFF);
        step(0, 1, 0, 8'h00, 8'h00);
        // counter saturation
        for (int i = 0; i < 20; i++) step(0, 1, 0, 8'h01, 8'h01);
        step(0, 1, 0, 8'h00, 8'h00);
        // randomized traffic with occasional clear/reset
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 29) == 0), 8'($urandom), 8'($urandom));
        end
        // async reset mid-stream with q=FF, checked before the next clock edge
        step(0, 1, 0, 8'hFF, 8'h00);
        step(0, 1, 0, 8'hFF, 8'h00);
        step(1, 1, 0, 8'hFF, 8'h00);
        step(1, 1, 0, 8'hFF, 8'h00);
        step(0, 1, 0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
